touchscreen_event_fifo: RTL
===========================

Name: touchscreen_event_fifo

Overview:
- Parametrised successor to the single-word touchscreen interface.
- Accepts raw X/Y samples from the touchscreen controller and classifies them into pen events: DOWN, MOVE and UP. UP is generated by a timeout.
- Filters sub-threshold jitter and buffers events in a FIFO with backpressure toward the controller.
- Presents packed 32-bit event words to the system bus side over a valid/ack handshake.

Parameters:
- CW, 12, coordinate width in bits, 1..12.
- DEPTH, 8, FIFO depth in events, power of 2, >=2.
- THRESH, 2, max |dx| and |dy| (inclusive) treated as jitter.
- PENUP_TIMEOUT, 1000000, idle cycles in ACTIVE before an UP event is generated, >=2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- TS_STB  in  1  sample strobe; controller holds it until TS_ACK
- TS_ACK  out  1  one-cycle acknowledge of an accepted sample
- TS_DAT_X  in  CW  X coordinate
- TS_DAT_Y  in  CW  Y coordinate
- O_STB  out  1  event word valid (FIFO non-empty)
- O_ACK  in  1  consumer takes head word
- O_DAT  out  32  {code[3:0], X zero-extended to 12, 4'd0, Y zero-extended to 12}
- PEN_ACTIVE  out  1  high in ACTIVE state
- FIFO_LVL  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK.
  - All outputs are 0 on reset: TS_ACK, O_STB, O_DAT, PEN_ACTIVE, FIFO_LVL.
  - State is IDLE, timer is 0, last-emitted coordinates are 0, FIFO is empty.
  - Reset mid-operation discards all buffered events; no UP event is emitted.
- Event codes:
  - 4'h8 = MOVE.
  - 4'h9 = DOWN.
  - 4'hA = UP.
- Accept condition: TS_STB=1, TS_ACK=0 and FIFO not full (registered full flag).
  - TS_ACK goes high for exactly the one cycle following the accept edge.
  - While the FIFO is full, the sample is held off: no ACK, no loss.
  - A pop in the same cycle does not unblock that cycle.
- State machine, IDLE:
  - An accepted sample writes a DOWN event with its coordinates.
  - State goes to ACTIVE, timer is cleared, last coordinates are updated.
- State machine, ACTIVE, accepted sample:
  - The timer is cleared.
  - If the filter passes, a MOVE is written and last coordinates are updated.
  - Otherwise the sample is ACKed and discarded; last coordinates are unchanged.
- State machine, ACTIVE, timer:
  - Increments by 1 on each cycle with TS_STB=0 and no accept; it saturates at PENUP_TIMEOUT.
  - When timer==PENUP_TIMEOUT and the FIFO is not full, write UP carrying the last coordinates. State goes to IDLE and the timer is cleared.
  - If the FIFO is full, UP waits, state stays ACTIVE, and UP is retried every cycle.
  - If an accept occurs in the same cycle as the pending UP, the sample wins (MOVE/discard rules apply) and the timer is cleared.
- Filter: a sample is a jitter sample when |X-lastX|<=THRESH and |Y-lastY|<=THRESH. Differences are computed unsigned in CW+1 bits with no wrap.
- Write latency: an event written at edge N gives O_STB=1 and valid O_DAT after edge N.
- FIFO behaviour:
  - O_DAT always shows the head word.
  - Pop occurs on O_STB & O_ACK.
  - O_ACK while empty is ignored.
  - Simultaneous push and pop when not full: FIFO_LVL is unchanged and order is preserved.
  - Pointers wrap modulo DEPTH.
  - FIFO_LVL ranges 0..DEPTH.
- At most one write per cycle.

Optional Feature:
- Macro: TOUCHSCREEN_EVENT_DEDUP_EN.
- When defined: the jitter filter above is active.
- When undefined: every ACTIVE-state sample is written as MOVE, and THRESH is ignored. DOWN and UP behaviour is unchanged.

Test Plan:
- Bench parameters: CW=12, DEPTH=4, THRESH=2, PENUP_TIMEOUT=16, dedup enabled.
- Single sample X=0x123, Y=0x456 from IDLE, O_ACK held 1:
  - TS_ACK pulses 1 cycle; O_STB rises 1 cycle after accept.
  - O_DAT=0x91230456 (DOWN), PEN_ACTIVE=1.
  - After 16 idle cycles, O_DAT=0xA1230456 (UP) and PEN_ACTIVE=0.
- Jitter and move, samples (100,100), (101,102), (103,100):
  - Output words are 0x90640064 (DOWN), then 0x80670064 (MOVE).
  - The middle sample is ACKed and dropped.
  - Repeat with the macro undefined: three words are output.
- Backpressure, O_ACK=0, six samples far apart:
  - FIFO_LVL reaches 4 and TS_ACK stays low on the 5th sample; no data is lost.
  - Release O_ACK: the 6 events are read in order (DOWN then 5 MOVE).
- UP stall, FIFO full when the timeout expires:
  - UP is delayed until the first pop, then appears as the last word.
- Sample on the timeout cycle:
  - A sample presented on the cycle timer==16 gives MOVE; no UP is emitted and PEN_ACTIVE stays 1.
- Reset mid-operation:
  - RST asserted with 3 events buffered: O_STB=0 and FIFO_LVL=0 immediately (asynchronous).
  - The next sample produces a DOWN event.

Source files
------------

// File: rtl/touchscreen_event_fifo_if.sv
// Sample-side and event-side handshake bundle for touchscreen_event_fifo.
interface touchscreen_event_fifo_if #(
  parameter int CW = 12,
  parameter int LW = 4
);
  logic          TS_STB;
  logic          TS_ACK;
  logic [CW-1:0] TS_DAT_X;
  logic [CW-1:0] TS_DAT_Y;
  logic          O_STB;
  logic          O_ACK;
  logic [31:0]   O_DAT;
  logic          PEN_ACTIVE;
  logic [LW-1:0] FIFO_LVL;

  modport slave (
    input  TS_STB, TS_DAT_X, TS_DAT_Y, O_ACK,
    output TS_ACK, O_STB, O_DAT, PEN_ACTIVE, FIFO_LVL
  );

  modport master (
    output TS_STB, TS_DAT_X, TS_DAT_Y, O_ACK,
    input  TS_ACK, O_STB, O_DAT, PEN_ACTIVE, FIFO_LVL
  );
endinterface

// File: rtl/touchscreen_event_fifo.sv
// Touchscreen pen-event classifier (DOWN/MOVE/UP) with event FIFO.
// TOUCHSCREEN_EVENT_DEDUP_EN enables the jitter filter on ACTIVE-state samples.
module touchscreen_event_fifo #(
  parameter int CW            = 12,
  parameter int DEPTH         = 8,
  parameter int THRESH        = 2,
  parameter int PENUP_TIMEOUT = 1000000
) (
  input  logic CLK,
  input  logic RST,
  touchscreen_event_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(PENUP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(PENUP_TIMEOUT);
  localparam logic [3:0] EV_MOVE = 4'h8;
  localparam logic [3:0] EV_DOWN = 4'h9;
  localparam logic [3:0] EV_UP   = 4'hA;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, nxt_state;
  logic [TW-1:0] timer, nxt_timer;
  logic [CW-1:0] last_x, last_y;
  logic          ts_ack;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   lvl;

  logic          full, accept, pop, push, upd_last, pass;
  logic [3:0]    push_code;
  logic [CW-1:0] push_x, push_y;
  logic [31:0]   push_word;

  // Full is taken from the registered level, so a same-cycle pop cannot unblock an accept.
  assign full   = (lvl == (AW+1)'(DEPTH));
  assign accept = bus.TS_STB & ~ts_ack & ~full;
  assign pop    = (lvl != '0) & bus.O_ACK;

`ifdef TOUCHSCREEN_EVENT_DEDUP_EN
  logic [CW:0] dx, dy;
  assign dx   = (bus.TS_DAT_X >= last_x) ? ({1'b0, bus.TS_DAT_X} - {1'b0, last_x})
                                         : ({1'b0, last_x} - {1'b0, bus.TS_DAT_X});
  assign dy   = (bus.TS_DAT_Y >= last_y) ? ({1'b0, bus.TS_DAT_Y} - {1'b0, last_y})
                                         : ({1'b0, last_y} - {1'b0, bus.TS_DAT_Y});
  assign pass = !((int'(dx) <= THRESH) && (int'(dy) <= THRESH));
`else
  assign pass = 1'b1;
`endif

  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    push      = 1'b0;
    push_code = EV_MOVE;
    push_x    = bus.TS_DAT_X;
    push_y    = bus.TS_DAT_Y;
    upd_last  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          push      = 1'b1;
          push_code = EV_DOWN;
          upd_last  = 1'b1;
          nxt_state = ACTIVE;
          nxt_timer = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          // A sample beats a pending UP on the same cycle.
          nxt_timer = '0;
          if (pass) begin
            push     = 1'b1;
            upd_last = 1'b1;
          end
        end else if (timer == TMAX) begin
          if (!full) begin
            push      = 1'b1;
            push_code = EV_UP;
            push_x    = last_x;
            push_y    = last_y;
            nxt_state = IDLE;
            nxt_timer = '0;
          end
        end else if (!bus.TS_STB) begin
          nxt_timer = timer + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign push_word = {push_code, 12'(push_x), 4'd0, 12'(push_y)};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      timer  <= '0;
      last_x <= '0;
      last_y <= '0;
      ts_ack <= 1'b0;
    end else begin
      state  <= nxt_state;
      timer  <= nxt_timer;
      ts_ack <= accept;
      if (upd_last) begin
        last_x <= bus.TS_DAT_X;
        last_y <= bus.TS_DAT_Y;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Storage needs no reset; the read port is masked while empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= push_word;
  end

  assign bus.TS_ACK     = ts_ack;
  assign bus.O_STB      = (lvl != '0);
  assign bus.O_DAT      = (lvl != '0) ? mem[rptr] : 32'd0;
  assign bus.PEN_ACTIVE = (state == ACTIVE);
  assign bus.FIFO_LVL   = lvl;
endmodule
